proc_control_unit: RTL and testbench

- Multi-cycle control FSM that sits directly upstream of the n-bit ALU in the enhanced processor.
- Holds the instruction register (IR) and decodes it; sequences fetch and execute over steps T0..T5.
- Drives the datapath bus mux, register enables, and the ALU controls (op, add_sub_control, cin).
- Latches the ALU zero and carry flags for conditional branches.

---
 rtl/proc_control_unit_pkg.sv | 30 +++
 rtl/proc_control_unit_cond_eval.sv | 24 ++
 rtl/proc_control_unit.sv | 177 +++++++++++++++++
 tb/tb_proc_control_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_control_unit_pkg.sv
// Shared encodings for the processor control unit and the ALU it drives.
// Opcodes, branch conditions, bus source codes, step encoding and ALU ops.
package proc_control_unit_pkg;

  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_B   = 3'd7;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_CC = 3'd3;
  localparam logic [2:0] COND_CS = 3'd4;

  localparam logic [3:0] BUS_R7  = 4'd7;
  localparam logic [3:0] BUS_G   = 4'd8;
  localparam logic [3:0] BUS_IMM = 4'd9;
  localparam logic [3:0] BUS_DIN = 4'd10;

  localparam logic [1:0] ALU_ADDSUB = 2'b00;
  localparam logic [1:0] ALU_AND    = 2'b01;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} step_t;

endpackage

// File: rtl/proc_control_unit_cond_eval.sv
// Branch condition evaluation from the latched zero/carry flags.
// Latency: combinational. Backpressure: none.
module proc_cond_eval
  import proc_control_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z_q,
  input  logic       c_q,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z_q;
      COND_NE: taken = ~z_q;
      COND_CC: taken = ~c_q;
      COND_CS: taken = c_q;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle fetch/execute sequencer driving bus mux, register enables and ALU controls.
// Latency: 4-6 cycles per instruction (T0..T5). Backpressure: none, run sampled only in T0.
module proc_control_unit
  import proc_control_unit_pkg::*;
#(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         run,
  input  logic [n-1:0] din,
  input  logic         alu_z,
  input  logic         alu_cout,
  output logic [3:0]   bus_sel,
  output logic [n-1:0] imm_out,
  output logic [7:0]   r_in,
  output logic         pc_incr,
  output logic         a_in,
  output logic         g_in,
  output logic         addr_in,
  output logic         dout_in,
  output logic         w_d,
  output logic [1:0]   alu_op,
  output logic         add_sub_control,
  output logic         cin,
  output logic         z_q,
  output logic         c_q,
  output logic         done
);

  step_t        step_q, step_d;
  logic [n-1:0] ir_q;
  logic [n-1:0] imm_dec;
  logic [2:0]   opc, rx, ry;
  logic [3:0]   src_sel;
  logic [7:0]   rx_oh;
  logic         is_alu, taken;

  assign opc     = ir_q[15:13];
  assign rx      = ir_q[11:9];
  assign ry      = ir_q[2:0];
  assign src_sel = ir_q[12] ? BUS_IMM : {1'b0, ry};
  assign rx_oh   = 8'd1 << rx;
  assign is_alu  = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND);

  proc_cond_eval u_cond (
    .cond  (rx),
    .z_q   (z_q),
    .c_q   (c_q),
    .taken (taken)
  );

  always_comb begin
    imm_dec = '0;
    case (opc)
      OP_MVT:  imm_dec[15:8] = ir_q[7:0];
      OP_B:    imm_dec = {{(n-9){ir_q[8]}}, ir_q[8:0]};
      default: imm_dec[8:0] = ir_q[8:0];
    endcase
  end

  // The previous instruction's immediate stays off the bus while fetching.
  assign imm_out = (step_q == T3 || step_q == T4 || step_q == T5) ? imm_dec : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_q <= T0;
      ir_q   <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
    end else begin
      step_q <= step_d;
      if (step_q == T2) ir_q <= din;
      if (step_q == T4 && is_alu) begin
        z_q <= alu_z;
        c_q <= alu_cout;
      end
    end
  end

  always_comb begin
    step_d          = step_q;
    bus_sel         = 4'd0;
    r_in            = 8'd0;
    pc_incr         = 1'b0;
    a_in            = 1'b0;
    g_in            = 1'b0;
    addr_in         = 1'b0;
    dout_in         = 1'b0;
    w_d             = 1'b0;
    alu_op          = ALU_ADDSUB;
    add_sub_control = 1'b0;
    cin             = 1'b0;
    done            = 1'b0;
    case (step_q)
      T0: if (run) begin
        bus_sel = BUS_R7;
        addr_in = 1'b1;
        pc_incr = 1'b1;
        step_d  = T1;
      end
      T1: step_d = T2;
      T2: step_d = T3;
      T3: begin
        step_d = T4;
        case (opc)
          OP_MV, OP_MVT: begin
            bus_sel = (opc == OP_MV) ? src_sel : BUS_IMM;
            r_in    = rx_oh;
            done    = 1'b1;
            step_d  = T0;
          end
          OP_LD, OP_ST: begin
            bus_sel = {1'b0, ry};
            addr_in = 1'b1;
          end
          OP_B: if (taken) begin
            bus_sel = BUS_R7;
            a_in    = 1'b1;
          end else begin
            done   = 1'b1;
            step_d = T0;
          end
          default: begin
            bus_sel = {1'b0, rx};
            a_in    = 1'b1;
          end
        endcase
      end
      T4: begin
        step_d = T5;
        case (opc)
          OP_ADD, OP_SUB, OP_AND: begin
            bus_sel         = src_sel;
            g_in            = 1'b1;
            alu_op          = (opc == OP_AND) ? ALU_AND : ALU_ADDSUB;
            add_sub_control = (opc == OP_SUB);
            cin             = (opc == OP_SUB);
          end
          OP_ST: begin
            bus_sel = {1'b0, rx};
            dout_in = 1'b1;
            w_d     = 1'b1;
            done    = 1'b1;
            step_d  = T0;
          end
          OP_B: begin
            bus_sel = BUS_IMM;
            g_in    = 1'b1;
          end
          OP_LD:   step_d = T5;
          default: step_d = T0;
        endcase
      end
      T5: begin
        step_d = T0;
        done   = 1'b1;
        case (opc)
          OP_LD: begin
            bus_sel = BUS_DIN;
            r_in    = rx_oh;
          end
          OP_B: begin
            bus_sel = BUS_G;
            r_in    = 8'h80;
          end
          default: begin
            bus_sel = BUS_G;
            r_in    = rx_oh;
          end
        endcase
      end
      default: step_d = T0;
    endcase
  end

endmodule

// File: tb/tb_proc_control_unit.sv
// Self-checking bench for proc_control_unit: directed vector table, reset corner, random instructions.
module tb_proc_control_unit;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         run = 1'b0;
  logic         alu_z = 1'b0;
  logic         alu_cout = 1'b0;
  logic [N-1:0] din = '0;
  logic [3:0]   bus_sel;
  logic [N-1:0] imm_out;
  logic [7:0]   r_in;
  logic         pc_incr, a_in, g_in, addr_in, dout_in, w_d;
  logic [1:0]   alu_op;
  logic         add_sub_control, cin, z_q, c_q, done;

  always #5 clk = ~clk;

  proc_control_unit #(.n(N)) dut (
    .clk(clk), .resetn(resetn), .run(run), .din(din), .alu_z(alu_z), .alu_cout(alu_cout),
    .bus_sel(bus_sel), .imm_out(imm_out), .r_in(r_in), .pc_incr(pc_incr), .a_in(a_in),
    .g_in(g_in), .addr_in(addr_in), .dout_in(dout_in), .w_d(w_d), .alu_op(alu_op),
    .add_sub_control(add_sub_control), .cin(cin), .z_q(z_q), .c_q(c_q), .done(done)
  );

  typedef struct packed {
    logic [3:0]  bus;
    logic [15:0] imm;
    logic [7:0]  rin;
    logic        pci, ain, gin, adr, dti, wd;
    logic [1:0]  op;
    logic        sub, ci, dn, z, c;
  } obs_t;

  typedef struct {
    logic [15:0] ins;
    bit          az, ac;
    int          len;
    logic [7:0]  rin;
    bit          z, c;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   zm = 1'b0;
  bit   cm = 1'b0;
  obs_t exp_q[$];
  vec_t tbl[15];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  function automatic obs_t sample();
    return {bus_sel, imm_out, r_in, pc_incr, a_in, g_in, addr_in, dout_in, w_d,
            alu_op, add_sub_control, cin, done, z_q, c_q};
  endfunction

  function automatic obs_t blank(input logic [15:0] im);
    obs_t o = '0;
    o.imm = im;
    o.z   = zm;
    o.c   = cm;
    return o;
  endfunction

  // Expand one instruction into its expected per-cycle outputs and update the flag model.
  task automatic build(input logic [15:0] ins, input bit az, input bit ac);
    logic [2:0]  opc, rx, ry;
    logic [15:0] imm;
    logic [3:0]  srcb;
    bit          tk;
    obs_t        o;
    opc  = ins[15:13];
    rx   = ins[11:9];
    ry   = ins[2:0];
    srcb = ins[12] ? 4'd9 : {1'b0, ry};
    if (opc == 3'd1)      imm = ins[7:0] * 16'd256;
    else if (opc == 3'd7) imm = 16'(int'(ins[8:0]) - (ins[8] ? 512 : 0));
    else                  imm = 16'(ins[8:0]);
    case (rx)
      3'd0:    tk = 1'b1;
      3'd1:    tk = zm;
      3'd2:    tk = !zm;
      3'd3:    tk = !cm;
      3'd4:    tk = cm;
      default: tk = 1'b0;
    endcase
    exp_q.delete();
    o = blank('0); o.bus = 4'd7; o.adr = 1'b1; o.pci = 1'b1; exp_q.push_back(o);
    exp_q.push_back(blank('0));
    exp_q.push_back(blank('0));
    case (opc)
      3'd0, 3'd1: begin
        o = blank(imm); o.bus = (opc == 3'd0) ? srcb : 4'd9; o.rin = 8'd1 << rx; o.dn = 1'b1;
        exp_q.push_back(o);
      end
      3'd2, 3'd3, 3'd6: begin
        o = blank(imm); o.bus = {1'b0, rx}; o.ain = 1'b1; exp_q.push_back(o);
        o = blank(imm); o.bus = srcb; o.gin = 1'b1; o.op = (opc == 3'd6) ? 2'b01 : 2'b00;
        o.sub = (opc == 3'd3); o.ci = (opc == 3'd3); exp_q.push_back(o);
        zm = az; cm = ac;
        o = blank(imm); o.bus = 4'd8; o.rin = 8'd1 << rx; o.dn = 1'b1; exp_q.push_back(o);
      end
      3'd4: begin
        o = blank(imm); o.bus = {1'b0, ry}; o.adr = 1'b1; exp_q.push_back(o);
        exp_q.push_back(blank(imm));
        o = blank(imm); o.bus = 4'd10; o.rin = 8'd1 << rx; o.dn = 1'b1; exp_q.push_back(o);
      end
      3'd5: begin
        o = blank(imm); o.bus = {1'b0, ry}; o.adr = 1'b1; exp_q.push_back(o);
        o = blank(imm); o.bus = {1'b0, rx}; o.dti = 1'b1; o.wd = 1'b1; o.dn = 1'b1;
        exp_q.push_back(o);
      end
      default: begin
        if (tk) begin
          o = blank(imm); o.bus = 4'd7; o.ain = 1'b1; exp_q.push_back(o);
          o = blank(imm); o.bus = 4'd9; o.gin = 1'b1; exp_q.push_back(o);
          o = blank(imm); o.bus = 4'd8; o.rin = 8'h80; o.dn = 1'b1; exp_q.push_back(o);
        end else begin
          o = blank(imm); o.dn = 1'b1; exp_q.push_back(o);
        end
      end
    endcase
  endtask

  // Entered and left just after a falling edge; run is randomised where it must be ignored.
  task automatic exec(input logic [15:0] ins, input bit az, input bit ac,
                      output int len, output logic [7:0] drin);
    obs_t got;
    build(ins, az, ac);
    din = ins; alu_z = az; alu_cout = ac;
    len = 0; drin = '0;
    for (int i = 0; i < exp_q.size(); i++) begin
      run = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      got = sample();
      chk($sformatf("cyc%0d ins=%h", i, ins), 64'(got), 64'(exp_q[i]));
      if (done && len == 0) begin
        len  = i + 1;
        drin = r_in;
      end
      @(negedge clk);
    end
    run = 1'b0;
  endtask

  task automatic idle(input int k);
    run = 1'b0;
    for (int i = 0; i < k; i++) begin
      #1;
      chk("idle", 64'(sample()), 64'(blank('0)));
      @(negedge clk);
    end
  endtask

  initial begin
    int          len;
    logic [7:0]  drin;
    logic [15:0] ins;
    tbl[0]  = '{16'h1005, 1, 1, 4, 8'h01, 0, 0};
    tbl[1]  = '{16'h6201, 1, 1, 6, 8'h02, 1, 1};
    tbl[2]  = '{16'hE3FE, 0, 0, 6, 8'h80, 1, 1};
    tbl[3]  = '{16'hA403, 0, 0, 5, 8'h00, 1, 1};
    tbl[4]  = '{16'h4000, 0, 0, 6, 8'h01, 0, 0};
    tbl[5]  = '{16'hE3FE, 1, 1, 4, 8'h00, 0, 0};
    tbl[6]  = '{16'h28AB, 1, 1, 4, 8'h10, 0, 0};
    tbl[7]  = '{16'h8A05, 1, 1, 6, 8'h20, 0, 0};
    tbl[8]  = '{16'hDC0F, 1, 0, 6, 8'h40, 1, 0};
    tbl[9]  = '{16'hE805, 0, 1, 4, 8'h00, 1, 0};
    tbl[10] = '{16'hE405, 0, 1, 4, 8'h00, 1, 0};
    tbl[11] = '{16'hE605, 0, 1, 6, 8'h80, 1, 0};
    tbl[12] = '{16'hEE05, 0, 1, 4, 8'h00, 1, 0};
    tbl[13] = '{16'hE005, 0, 1, 6, 8'h80, 1, 0};
    tbl[14] = '{16'h0E03, 0, 1, 4, 8'h80, 1, 0};

    #1;
    chk("reset_state", 64'(sample()), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    idle(2);

    // Back-to-back: each instruction starts in the cycle right after the previous done.
    foreach (tbl[i]) begin
      exec(tbl[i].ins, tbl[i].az, tbl[i].ac, len, drin);
      chk($sformatf("len[%0d]", i), 64'(len), 64'(tbl[i].len));
      chk($sformatf("rin[%0d]", i), 64'(drin), 64'(tbl[i].rin));
      chk($sformatf("flags[%0d]", i), 64'({z_q, c_q}), 64'({tbl[i].z, tbl[i].c}));
    end

    // Asynchronous reset while an add sits in T4, with flag inputs that would otherwise latch.
    din = 16'h4000; alu_z = 1'b1; alu_cout = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run = (i == 0);
      @(negedge clk);
    end
    run = 1'b0;
    #1;
    chk("t4_gin", 64'(g_in), 64'(1));
    resetn = 1'b0;
    #1;
    zm = 1'b0; cm = 1'b0;
    chk("rst_async", 64'(sample()), 64'(0));
    @(negedge clk);
    chk("rst_hold", 64'(sample()), 64'(0));
    resetn = 1'b1;
    idle(3);

    for (int t = 0; t < 300; t++) begin
      idle($urandom_range(0, 2));
      ins = 16'($urandom);
      exec(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len, drin);
      chk($sformatf("rand_done ins=%h", ins), 64'(len), 64'(exp_q.size()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
